// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - scans a 4-bit word through an external 4:1 mux and streams the sampled bits
//
// Latches a word, then steps the mux select through addresses 0..3. After each
// select change it waits SETTLE_CYCLES clocks, samples the fed-back mux output,
// and offers it downstream with a valid/ready handshake.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   word_in/valid/ready     word intake handshake (ready only while idle)
//   in0..in3                latched word bits driving the mux data inputs
//   address0, address1      mux select lines, address = {address1, address0}
//   mux_out                 mux output fed back for sampling
//   bit_out/valid/ready     sampled bit handshake to the consumer
//   word_done               one-cycle pulse after the fourth bit is consumed
//   mismatch                sticky flag: a sample disagreed with the latched bit

module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] word_in,
  input  logic       word_valid,
  output logic       word_ready,
  output logic       in0,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       address0,
  output logic       address1,
  input  logic       mux_out,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       word_done,
  output logic       mismatch
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    EMIT
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] settle_cnt;
  logic [1:0] address;
  logic [3:0] latched;

  // Ready is gated by reset directly so it reads 0 for the whole reset window,
  // including the very first edge before the state register is known.
  assign word_ready = (state == IDLE) && !reset;

  assign {in3, in2, in1, in0} = latched;
  assign address0             = address[0];
  assign address1             = address[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= 8'd0;
      address    <= 2'd0;
      latched    <= 4'd0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      word_done  <= 1'b0;
      mismatch   <= 1'b0;
    end else begin
      word_done <= 1'b0;
      case (state)
        IDLE: begin
          if (word_valid) begin
            latched    <= word_in;
            address    <= 2'd0;
            settle_cnt <= 8'd0;
            state      <= SETTLE;
          end
        end

        SETTLE: begin
          settle_cnt <= settle_cnt + 8'd1;
          // The counter starts at 0 on the select-change edge, so matching
          // SETTLE_LAST lands the sample exactly SETTLE_CYCLES edges later.
          if (settle_cnt == SETTLE_LAST) begin
            bit_out   <= mux_out;
            bit_valid <= 1'b1;
            if (mux_out != latched[address]) begin
              mismatch <= 1'b1;
            end
            state <= EMIT;
          end
        end

        EMIT: begin
          if (bit_ready) begin
            bit_valid <= 1'b0;
            if (address == 2'd3) begin
              word_done <= 1'b1;
              address   <= 2'd0;
              state     <= IDLE;
            end else begin
              address    <= address + 2'd1;
              settle_cnt <= 8'd0;
              state      <= SETTLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - randomized bench for mux_scan_sequencer with a timeline reference model
//
// Two instances (SETTLE_CYCLES=4 and =1) share all stimulus; sel picks which
// one is compared. The mux is modelled as a plain 4:1 select that can be
// forced to 0 to provoke mismatches.

module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] word_in = 4'd0;
  logic       word_valid = 1'b0;
  logic       bit_ready = 1'b0;
  logic       force0 = 1'b0;
  logic       sel = 1'b0;

  always #100 clk = ~clk;

  // Instance a: SETTLE_CYCLES = 4
  logic a_ready, a_in0, a_in1, a_in2, a_in3, a_addr0, a_addr1;
  logic a_mux, a_bit, a_valid, a_done, a_mis;
  logic [3:0] a_inv;
  assign a_inv = {a_in3, a_in2, a_in1, a_in0};
  assign a_mux = !force0 && a_inv[{a_addr1, a_addr0}];

  mux_scan_sequencer #(.SETTLE_CYCLES(4)) u_dut_a (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(a_ready), .in0(a_in0), .in1(a_in1), .in2(a_in2), .in3(a_in3),
    .address0(a_addr0), .address1(a_addr1), .mux_out(a_mux), .bit_out(a_bit),
    .bit_valid(a_valid), .bit_ready(bit_ready), .word_done(a_done), .mismatch(a_mis)
  );

  // Instance b: SETTLE_CYCLES = 1
  logic b_ready, b_in0, b_in1, b_in2, b_in3, b_addr0, b_addr1;
  logic b_mux, b_bit, b_valid, b_done, b_mis;
  logic [3:0] b_inv;
  assign b_inv = {b_in3, b_in2, b_in1, b_in0};
  assign b_mux = !force0 && b_inv[{b_addr1, b_addr0}];

  mux_scan_sequencer #(.SETTLE_CYCLES(1)) u_dut_b (
    .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
    .word_ready(b_ready), .in0(b_in0), .in1(b_in1), .in2(b_in2), .in3(b_in3),
    .address0(b_addr0), .address1(b_addr1), .mux_out(b_mux), .bit_out(b_bit),
    .bit_valid(b_valid), .bit_ready(bit_ready), .word_done(b_done), .mismatch(b_mis)
  );

  // Observed outputs of the selected instance
  logic       o_ready, o_bit, o_valid, o_done, o_mis;
  logic [3:0] o_in;
  logic [1:0] o_addr;
  always_comb begin
    o_ready = sel ? b_ready : a_ready;
    o_in    = sel ? b_inv : a_inv;
    o_addr  = sel ? {b_addr1, b_addr0} : {a_addr1, a_addr0};
    o_bit   = sel ? b_bit : a_bit;
    o_valid = sel ? b_valid : a_valid;
    o_done  = sel ? b_done : a_done;
    o_mis   = sel ? b_mis : a_mis;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, settle %0d)", tag, got, exp, cyc, sel ? 1 : 4);
    end
  endtask

  // Reference model: a word in flight is described by its bit index and the
  // absolute cycle at which that bit must be on offer; a select change at
  // edge e puts the sample in cycle e + settle.
  int         m_s = 4;
  bit         m_busy = 1'b0;
  logic [3:0] m_word = 4'd0;
  int         m_idx = 0;
  int         m_valid_at = 0;
  int         m_done_at = -1;
  bit         m_mis = 1'b0;
  bit         m_force = 1'b0;
  int         fixed_word = -1;

  function automatic bit exp_valid_now();
    return m_busy && (cyc >= m_valid_at);
  endfunction

  // One clock: check outputs for the current cycle, then choose inputs for the
  // next edge and advance the model accordingly.
  task automatic cycle(input int vpct, input int rpct);
    bit ev;
    @(negedge clk);
    ev = exp_valid_now();
    if (ev && cyc == m_valid_at && m_force && m_word[m_idx]) m_mis = 1'b1;
    check("word_ready", 8'(o_ready), 8'(!m_busy));
    check("bit_valid", 8'(o_valid), 8'(ev));
    check("address", 8'(o_addr), m_busy ? 8'(m_idx) : 8'd0);
    check("in_bits", 8'(o_in), 8'(m_word));
    check("word_done", 8'(o_done), 8'(cyc == m_done_at));
    check("mismatch", 8'(o_mis), 8'(m_mis));
    if (ev) check("bit_out", 8'(o_bit), m_force ? 8'd0 : 8'(m_word[m_idx]));

    word_valid = ($urandom_range(99) < vpct);
    word_in    = (fixed_word >= 0) ? 4'(fixed_word) : 4'($urandom);
    bit_ready  = ($urandom_range(99) < rpct);

    if (!m_busy && word_valid) begin
      m_busy     = 1'b1;
      m_word     = word_in;
      m_idx      = 0;
      m_valid_at = cyc + 1 + m_s;
    end else if (ev && bit_ready) begin
      if (m_idx < 3) begin
        m_idx++;
        m_valid_at = cyc + 1 + m_s;
      end else begin
        m_busy    = 1'b0;
        m_done_at = cyc + 1;
      end
    end
  endtask

  task automatic do_reset(input int n, input logic new_sel);
    @(negedge clk);
    reset      = 1'b1;
    word_valid = 1'b0;
    bit_ready  = 1'b0;
    sel        = new_sel;
    #1;
    check("ready_during_reset", 8'(o_ready), 8'd0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("rst_in_bits", 8'(o_in), 8'd0);
    check("rst_address", 8'(o_addr), 8'd0);
    check("rst_bit_out", 8'(o_bit), 8'd0);
    check("rst_bit_valid", 8'(o_valid), 8'd0);
    check("rst_word_done", 8'(o_done), 8'd0);
    check("rst_mismatch", 8'(o_mis), 8'd0);
    check("rst_word_ready", 8'(o_ready), 8'd0);
    reset     = 1'b0;
    m_s       = new_sel ? 1 : 4;
    m_busy    = 1'b0;
    m_word    = 4'd0;
    m_idx     = 0;
    m_done_at = -1;
    m_mis     = 1'b0;
  endtask

  initial begin
    bit hit;

    // Settle 4: back-to-back 4'b1010 with consumer always ready
    do_reset(2, 1'b0);
    fixed_word = 4'b1010;
    repeat (45) cycle(100, 100);
    fixed_word = 4'hC;
    repeat (25) cycle(100, 100);
    fixed_word = -1;

    // Random traffic, then heavy back-pressure
    repeat (300) cycle(50, 60);
    repeat (150) cycle(70, 15);

    // Reset while settling on address 2 must abort without word_done
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cycle(100, 100);
      if (m_busy && m_idx == 2 && cyc < m_valid_at) hit = 1'b1;
    end
    check("reach_settle_addr2", 8'(hit), 8'd1);
    do_reset(1, 1'b0);
    repeat (30) cycle(60, 80);

    // Mux stuck at 0: mismatch must latch and stay set across words
    do_reset(1, 1'b0);
    force0  = 1'b1;
    m_force = 1'b1;
    fixed_word = 4'b1111;
    repeat (12) cycle(100, 100);
    fixed_word = -1;
    repeat (150) cycle(80, 70);
    do_reset(1, 1'b0);
    force0  = 1'b0;
    m_force = 1'b0;
    repeat (40) cycle(80, 70);

    // Settle 1: no dead cycle between select change and sample
    do_reset(2, 1'b1);
    fixed_word = 4'b0110;
    repeat (30) cycle(100, 100);
    fixed_word = -1;
    repeat (250) cycle(60, 60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, is the number of clk cycles the mux path is allowed to settle after each address change; its legal range is 1..255.
REQ-002 Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit, is the synchronous, active-high reset.
REQ-004 Port word_in, input, 4 bits, is the data word to scan; bit k drives mux input k.
REQ-005 Port word_valid, input, 1 bit, indicates that word_in is valid.
REQ-006 Port word_ready, output, 1 bit, indicates that the block accepts a word this cycle.
REQ-007 Ports in0, in1, in2 and in3, outputs, 1 bit each, are the latched word bits that drive the 4:1 structuralMultiplexer data inputs.
REQ-008 Ports address0 and address1, outputs, 1 bit each, are the select lines to the mux (address = {address1, address0}).
REQ-009 Port mux_out, input, 1 bit, is the output of the mux fed back to this block.
REQ-010 Port bit_out, output, 1 bit, is the sampled mux output for the current address.
REQ-011 Port bit_valid, output, 1 bit, indicates that bit_out is valid.
REQ-012 Port bit_ready, input, 1 bit, indicates that the downstream consumer accepts bit_out.
REQ-013 Port word_done, output, 1 bit, is a one-cycle pulse after the fourth bit of a word is consumed.
REQ-014 Port mismatch, output, 1 bit, is a sticky flag set when a sampled bit differs from the expected latched bit.

Function
REQ-015 The FSM SHALL have three states: IDLE, SETTLE and EMIT; the encoding is implementer's choice.
REQ-016 word_ready SHALL be 1 exactly when the state is IDLE and reset is 0.
REQ-017 In IDLE, on word_valid & word_ready the block SHALL:
- latch word_in[0..3] into in0..in3;
- set the address to 0;
- clear the settle counter;
- move to SETTLE.
REQ-018 in0..in3 SHALL remain unchanged from acceptance until the next accepted word; they SHALL NOT change in SETTLE or EMIT.
REQ-019 In SETTLE the 8-bit settle counter SHALL increment once per cycle.
REQ-020 When the settle counter equals SETTLE_CYCLES-1, the block SHALL:
- register mux_out into bit_out;
- set bit_valid;
- move to EMIT.
REQ-021 The latency from the acceptance edge to bit_valid=1 SHALL be exactly SETTLE_CYCLES cycles; likewise from each address change to the corresponding bit_valid.
REQ-022 At the sampling edge, if mux_out differs from in[address], mismatch SHALL set to 1 and SHALL stay 1 until reset.
REQ-023 In EMIT, bit_valid and bit_out SHALL hold steady until the cycle in which bit_ready=1.
REQ-024 On an EMIT handshake with address < 3, the block SHALL:
- increment the address by 1;
- clear the settle counter;
- clear bit_valid;
- return to SETTLE.
REQ-025 On an EMIT handshake with address == 3, the block SHALL:
- clear bit_valid;
- pulse word_done for exactly one cycle;
- return the address to 0;
- enter IDLE.
REQ-026 The address SHALL change only on an acceptance or EMIT-handshake edge; it SHALL never wrap past 3.
REQ-027 With bit_ready held at 1, each bit SHALL take SETTLE_CYCLES+1 cycles, and a word with back-to-back acceptance SHALL take 4*(SETTLE_CYCLES+1)+1 cycles.
REQ-028 A word_valid asserted in the same cycle as the word_done pulse SHALL be accepted, because that is the first IDLE cycle.
REQ-029 word_valid outside IDLE SHALL be ignored; the block SHALL neither latch nor drop state.
REQ-030 With SETTLE_CYCLES=1, sampling SHALL occur on the first SETTLE cycle, with no dead cycle.

Reset
REQ-031 While reset=1 at a clk edge, the block SHALL force:
- state to IDLE and the settle counter to 0;
- in0..in3, address0, address1, bit_out, bit_valid, word_done and mismatch to 0;
- word_ready to 0 for the duration of reset.
REQ-032 Reset asserted mid-SETTLE or mid-EMIT SHALL abort the word; no word_done SHALL be generated, and word_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-033 SETTLE_CYCLES=4, bit_ready=1, word_in=4'b1010 accepted at cycle 0 -> bit_out sequence 0,1,0,1 at bit_valid cycles 4, 9, 14, 19; word_done at cycle 20; mismatch stays 0.
REQ-034 bit_ready held 0 for 6 cycles in EMIT of address 1 -> bit_valid, bit_out and address={0,1} stay stable; progress resumes one cycle after bit_ready=1.
REQ-035 Force mux_out=0 while word_in=4'b1111 -> mismatch=1 after the first sample; it stays 1 through the next word until reset.
REQ-036 word_valid held 1 with words 4'h3 then 4'hC -> the second word is accepted on the word_done cycle; in0..in3 change only at that edge.
REQ-037 Reset asserted during SETTLE of address 2 -> the next cycle shows all outputs 0 and state IDLE; after deassertion word_ready=1 and no word_done is seen.
REQ-038 SETTLE_CYCLES=1 with the real gate-delay mux and a 200 ns clk period -> all four bits match word_in=4'b0110 with no mismatch.
